gf163_reduce_pipe: RTL and testbench
====================================

# gf163_reduce_pipe

Two-stage pipelined reducer for GF(2^163) products modulo f(x) = x^163 + x^7 + x^6 + x^3 + 1. It consumes the 325-bit unreduced polynomial product from the Karatsuba multiplier tree, whose leaves are the 21-bit and 11-bit KA cores. It returns the 163-bit canonical field element over a valid/ready stream. Sustains one product per clock under no backpressure.

## Interface
Parameters:
- None. All widths are fixed by the field and come from the shared package.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  product on `in_data` is valid.
- `in_ready`  output  1  block accepts `in_data` this cycle.
- `in_data`  input  325  unreduced product c[324:0].
- `out_valid`  output  1  `out_data` holds a reduced result.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_data`  output  163  r = c mod f(x).
- `out_zero`  output  1  present only with `GF163_REDUCE_ZERO_FLAG_EN`. High when `out_data` == 0.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Stage 1 (first fold):
  - H = c[324:163], 162 bits.
  - t[168:0] = c[162:0] ^ H ^ (H<<3) ^ (H<<6) ^ (H<<7).
  - Stage 1 registers t and s1_valid.
- Stage 2 (second fold):
  - h2 = t[168:163], 6 bits.
  - r = t[162:0] ^ h2 ^ (h2<<3) ^ (h2<<6) ^ (h2<<7).
  - The maximum shifted bit is 12, so r is fully reduced.
  - Stage 2 registers r into `out_data` and sets `out_valid`.
- All arithmetic is carry-less XOR; no integer adds.
- Stage control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - `in_ready` = s1_adv, combinational from `out_ready` and the valid registers.
- Stage 2 load: when s2_adv, `out_valid` <= s1_valid, and the data register loads when s1_valid.
- Stage 1 load: when s1_adv, s1_valid <= in_valid, and t loads when in_valid.
- Data registers hold their value when not loading. Valid bits clear only on drain.
- Simultaneous output transfer and input transfer with both stages full: both stages shift in the same cycle and nothing is lost.
- Backpressure: with `out_ready` low and both stages full, `in_ready` = 0. `out_data` stays stable while `out_valid && !out_ready`.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` when no stall occurs.
- Throughput: 1 result per cycle.
- Reset (asynchronous assert, synchronous release):
  - s1_valid = 0, t = 0.
  - `out_valid` = 0, `out_data` = 0, `out_zero` = 0.
  - `in_ready` reads 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight products. No partial result is ever emitted.
- No combinational path runs from `in_data` to any output.

## Configuration
- `GF163_REDUCE_ZERO_FLAG_EN` defined:
  - Adds the `out_zero` port.
  - `out_zero` is registered in the same cycle as `out_data` and is computed from r.
  - It holds with `out_data` under stall.
- Undefined: the port and its register are absent. Reduction behaviour is identical.

## Structure
- Package `gf163_pkg` holds:
  - `GF_M` = 163.
  - `GF_PROD_W` = 325.
  - `GF_FOLD_W` = 169.
  - Tap offsets 3, 6, 7.
  - Typedefs `gf_elem_t` [162:0] and `gf_prod_t` [324:0].
- Sub-module `gf163_fold`: combinational, parameterised on high-part width HW. Output = low ^ hi ^ hi<<3 ^ hi<<6 ^ hi<<7.
  - Stage 1 instance: HW = 162.
  - Stage 2 instance: HW = 6.

## Test plan
- c = 0x1234 (degree < 163), `out_ready` = 1 → `out_data` = 0x1234, two cycles after the input transfer.
- c = x^163 → `out_data` = 0xC9 (x^7+x^6+x^3+1).
- c = x^324 → `out_data` = x^161 + 0x1422 (bits 161, 12, 10, 5, 1).
- Back-to-back stream:
  - Stimulus: 100 random products, `out_ready` = 1.
  - Response: 100 results in order, matching the reference model, one per cycle. `in_ready` stays 1 throughout.
- Backpressure:
  - Stimulus: 4 inputs offered, `out_ready` = 0 for 6 cycles.
  - Response: exactly 2 inputs are accepted, then `in_ready` = 0 and `out_data` is stable. After `out_ready` rises, all 4 results emerge in order with no duplicates.
- Reset mid-operation:
  - Stimulus: assert `rst_n` = 0 with both stages full.
  - Response: `out_valid` = 0 and `out_data` = 0 immediately. Nothing is emitted after release until new input arrives.
- With `GF163_REDUCE_ZERO_FLAG_EN` defined, c = f(x) (bits 163, 7, 6, 3, 0) → `out_data` = 0 and `out_zero` = 1.

Source files
------------

// File: rtl/gf163_pkg.sv
// Shared constants and types for GF(2^163) reduction modulo
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;
  localparam int GF_M      = 163;
  localparam int GF_PROD_W = 325;
  localparam int GF_FOLD_W = 169;
  localparam int GF_TAP_A  = 3;
  localparam int GF_TAP_B  = 6;
  localparam int GF_TAP_C  = 7;

  typedef logic [GF_M-1:0]      gf_elem_t;
  typedef logic [GF_PROD_W-1:0] gf_prod_t;
endpackage

// File: rtl/gf163_reduce_pipe_fold.sv
// One carry-less fold step: res = low ^ hi ^ hi<<3 ^ hi<<6 ^ hi<<7.
// OW defaults to the wider of the field width and the top shifted bit.
module gf163_fold
  import gf163_pkg::*;
#(
  parameter int HW = 162,
  parameter int OW = (HW + GF_TAP_C > GF_M) ? (HW + GF_TAP_C) : GF_M
) (
  input  logic [GF_M-1:0] low,
  input  logic [HW-1:0]   hi,
  output logic [OW-1:0]   res
);
  logic [OW-1:0] low_ext;
  logic [OW-1:0] hi_ext;

  always_comb begin
    low_ext = '0;
    low_ext[GF_M-1:0] = low;
    hi_ext = '0;
    hi_ext[HW-1:0] = hi;
    res = low_ext ^ hi_ext ^ (hi_ext << GF_TAP_A) ^ (hi_ext << GF_TAP_B)
        ^ (hi_ext << GF_TAP_C);
  end
endmodule

// File: rtl/gf163_reduce_pipe.sv
// Two-stage pipelined reducer of 325-bit GF(2) products to GF(2^163) elements.
// Optional out_zero flag is enabled by defining GF163_REDUCE_ZERO_FLAG_EN.
module gf163_reduce_pipe
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [324:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [162:0] out_data
`ifdef GF163_REDUCE_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);
  // Handshake: a beat transfers on a rising edge where valid && ready; a stage
  // advances when it is empty or its downstream consumer takes its beat.
  logic                 s2_adv;
  logic                 s1_adv;
  logic                 s1_valid_q, s1_valid_d;
  logic [GF_FOLD_W-1:0] t_q, t_d;
  logic                 out_valid_q, out_valid_d;
  gf_elem_t             out_data_q, out_data_d;
  logic [GF_FOLD_W-1:0] t_fold;
  gf_elem_t             r_fold;

  gf163_fold #(.HW(GF_PROD_W - GF_M), .OW(GF_FOLD_W)) u_fold1 (
    .low (in_data[GF_M-1:0]),
    .hi  (in_data[GF_PROD_W-1:GF_M]),
    .res (t_fold)
  );

  gf163_fold #(.HW(GF_FOLD_W - GF_M), .OW(GF_M)) u_fold2 (
    .low (t_q[GF_M-1:0]),
    .hi  (t_q[GF_FOLD_W-1:GF_M]),
    .res (r_fold)
  );

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) t_d = t_fold;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = r_fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef GF163_REDUCE_ZERO_FLAG_EN
  logic out_zero_q, out_zero_d;

  // Loads alongside out_data so the flag always describes the held result.
  always_comb begin
    out_zero_d = out_zero_q;
    if (s2_adv && s1_valid_q) out_zero_d = (r_fold == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_zero_q <= 1'b0;
    else        out_zero_q <= out_zero_d;
  end

  assign out_zero = out_zero_q;
`endif

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_gf163_reduce_pipe.sv
// Randomised and directed bench for gf163_reduce_pipe with a long-division
// reference model, an expected-result queue and a negedge monitor.
module tb_gf163_reduce_pipe;
  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [324:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [162:0] out_data;
`ifdef GF163_REDUCE_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks = 0;
  int errors = 0;
  int n_recv = 0;
  logic [162:0] exp_q[$];

  gf163_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef GF163_REDUCE_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook long division by f(x), top bit down.
  function automatic logic [162:0] ref_mod(input logic [324:0] c);
    logic [324:0] a;
    logic [324:0] f;
    a = c;
    f = '0;
    f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    for (int i = 324; i >= 163; i--)
      if (a[i]) a = a ^ (f << (i - 163));
    return a[162:0];
  endfunction

  function automatic logic [324:0] rand_prod();
    logic [324:0] v;
    v = '0;
    for (int k = 0; k < 11; k++) v = (v << 32) | 325'($urandom);
    return v;
  endfunction

  task automatic check(input string name, input logic [162:0] act, input logic [162:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver: one clock; records acceptance at negedge, returns at posedge+1
  task automatic step(input logic [162:0] exp, output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [324:0] d, input logic [162:0] exp);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      step(exp, acc);
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) check("send_accept_timeout", 163'd0, 163'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(1);
    check("drain_empty", 163'(exp_q.size()), 163'd0);
  endtask

  // scoreboard monitor
  logic         have_hold;
  logic [162:0] hold_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("stall_valid", 163'(out_valid), 163'd1);
        check("stall_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        n_recv++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_data, 163'd0);
          if (out_data == 163'd0) begin
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data);
          end
        end else begin
          logic [162:0] e;
          e = exp_q.pop_front();
          check("result", out_data, e);
`ifdef GF163_REDUCE_ZERO_FLAG_EN
          check("zero_flag", 163'(out_zero), 163'(e == 163'd0));
`endif
        end
      end
      have_hold = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  initial begin
    logic [324:0] d;
    logic [324:0] bp_d[4];
    bit acc;
    int acc_n, base;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 163'(out_valid), 163'd0);
    check("rst_out_data", out_data, 163'd0);
    check("rst_in_ready", 163'(in_ready), 163'd1);
`ifdef GF163_REDUCE_ZERO_FLAG_EN
    check("rst_out_zero", 163'(out_zero), 163'd0);
`endif
    @(posedge clk); #1;

    // low-degree pass-through and latency
    send(325'h1234, 163'h1234);
    @(negedge clk);
    check("lat_cycle1_valid", 163'(out_valid), 163'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_valid", 163'(out_valid), 163'd1);
    check("lat_cycle2_data", out_data, 163'h1234);
    @(posedge clk); #1;

    d = '0; d[163] = 1'b1;
    send(d, 163'hC9);
    d = '0; d[324] = 1'b1;
    send(d, (163'd1 << 161) | 163'h1422);
`ifdef GF163_REDUCE_ZERO_FLAG_EN
    d = '0; d[163] = 1'b1; d[7] = 1'b1; d[6] = 1'b1; d[3] = 1'b1; d[0] = 1'b1;
    send(d, 163'd0);
`endif
    drain();

    // back-to-back random stream
    base = n_recv;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = rand_prod();
      step(ref_mod(in_data), acc);
      check("stream_in_ready", 163'(acc), 163'd1);
      if (i >= 2) check("stream_out_valid", 163'(out_valid), 163'd1);
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 163'(n_recv - base), 163'd100);

    // backpressure
    base = n_recv;
    for (int i = 0; i < 4; i++) bp_d[i] = rand_prod();
    out_ready = 1'b0;
    acc_n = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = bp_d[acc_n < 4 ? acc_n : 3];
      step(ref_mod(in_data), acc);
      if (acc) acc_n++;
    end
    check("bp_accepted", 163'(acc_n), 163'd2);
    @(negedge clk);
    check("bp_in_ready", 163'(in_ready), 163'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && acc_n < 4; c++) begin
      in_data = bp_d[acc_n];
      step(ref_mod(in_data), acc);
      if (acc) acc_n++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 163'(acc_n), 163'd4);
    drain();
    check("bp_count", 163'(n_recv - base), 163'd4);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = rand_prod();
      step(ref_mod(in_data), acc);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 163'(out_valid), 163'd0);
    check("midrst_out_data", out_data, 163'd0);
    exp_q.delete();
    idle(2);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_recv;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_idle", 163'(out_valid), 163'd0);
    end
    check("post_rst_count", 163'(n_recv - base), 163'd0);
    @(posedge clk); #1;
    in_data = rand_prod();
    send(in_data, ref_mod(in_data));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
